// File: rtl/demux4_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package demux4_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef logic [SEL_W-1:0] sel_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    localparam int CNT_RST  = 0;
    localparam int DATA_RST = 0;

endpackage

// File: rtl/demux4_stream_if.sv
// Handshake bundle between one producer, the demux and four consumers.
interface demux4_stream_if
    import demux4_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic                      in_valid;
    logic                      in_ready;
    sel_t                      in_sel;
    logic [DATA_W-1:0]         in_data;
    logic [NUM_CH-1:0]         out_valid;
    logic [NUM_CH-1:0]         out_ready;
    logic [NUM_CH*DATA_W-1:0]  out_data;
    logic [NUM_CH*CNT_W-1:0]   xfer_cnt;
    logic                      sel_err;

    modport master (
        output in_valid, in_sel, in_data, out_ready,
        input  in_ready, out_valid, out_data, xfer_cnt, sel_err
    );

    modport slave (
        input  in_valid, in_sel, in_data, out_ready,
        output in_ready, out_valid, out_data, xfer_cnt, sel_err
    );
endinterface

// File: rtl/demux4_slot.sv
// One-entry output holding register with valid flag and handshake counter.
module demux4_slot
    import demux4_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [CNT_W-1:0]  o_cnt
);
    slot_state_t       r_state;
    slot_state_t       w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_drain;

    assign o_valid = (r_state == SLOT_FULL);
    assign o_data  = r_data;
    assign o_cnt   = r_cnt;
    assign w_drain = o_valid & i_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SLOT_EMPTY;
            r_data  <= DATA_W'(DATA_RST);
            r_cnt   <= CNT_W'(CNT_RST);
        end else begin
            r_state <= w_state_nxt;
            if (i_load)  r_data <= i_data;
            if (w_drain) r_cnt  <= r_cnt + CNT_W'(1);
        end
    end

    // A load while full only happens together with a drain, so FULL stays FULL.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            SLOT_EMPTY: if (i_load) w_state_nxt = SLOT_FULL;
            SLOT_FULL:  if (!i_load && i_ready) w_state_nxt = SLOT_EMPTY;
            default:    w_state_nxt = SLOT_EMPTY;
        endcase
    end
endmodule

// File: rtl/demux4_stream.sv
// 1-to-4 valid/ready stream demux with per-channel holding slots and a sticky
// protocol-error flag. Define DEMUX4_RR_EN to route by an internal round-robin pointer.
module demux4_stream
    import demux4_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input logic            clk,
    input logic            rst,
    demux4_stream_if.slave bus
);
    sel_t              w_sel;
    logic              w_sel_chg;
    logic              w_in_ready;
    logic              w_xfer;
    logic              w_err;
    logic [NUM_CH-1:0] w_load;
    logic              r_stall;
    logic [DATA_W-1:0] r_prev_data;
    logic              r_sel_err;

`ifdef DEMUX4_RR_EN
    sel_t r_ptr;

    always_ff @(posedge clk) begin
        if (rst)         r_ptr <= '0;
        else if (w_xfer) r_ptr <= r_ptr + SEL_W'(1);
    end

    assign w_sel     = r_ptr;
    assign w_sel_chg = 1'b0;
`else
    sel_t r_prev_sel;

    always_ff @(posedge clk) begin
        if (rst) r_prev_sel <= '0;
        else     r_prev_sel <= bus.in_sel;
    end

    assign w_sel     = bus.in_sel;
    assign w_sel_chg = (bus.in_sel != r_prev_sel);
`endif

    assign w_in_ready   = !rst && (!bus.out_valid[w_sel] || bus.out_ready[w_sel]);
    assign w_xfer       = bus.in_valid && w_in_ready;
    assign bus.in_ready = w_in_ready;
    assign bus.sel_err  = r_sel_err;

    // A stalled offer must be held unchanged until it is taken.
    assign w_err = r_stall && (!bus.in_valid || w_sel_chg || (bus.in_data != r_prev_data));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall     <= 1'b0;
            r_prev_data <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            r_stall     <= bus.in_valid && !w_in_ready;
            r_prev_data <= bus.in_data;
            if (w_err) r_sel_err <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_slot
        assign w_load[k] = w_xfer && (w_sel == sel_t'(k));

        demux4_slot #(
            .DATA_W (DATA_W),
            .CNT_W  (CNT_W)
        ) u_slot (
            .clk     (clk),
            .rst     (rst),
            .i_load  (w_load[k]),
            .i_data  (bus.in_data),
            .i_ready (bus.out_ready[k]),
            .o_valid (bus.out_valid[k]),
            .o_data  (bus.out_data[k*DATA_W +: DATA_W]),
            .o_cnt   (bus.xfer_cnt[k*CNT_W +: CNT_W])
        );
    end
endmodule

// File: tb/tb_demux4_stream.sv
// Scoreboard bench for demux4_stream; define DEMUX4_RR_EN to exercise round-robin routing.
module tb_demux4_stream;
    import demux4_pkg::*;

    localparam int DW = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux4_stream_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

    demux4_stream #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW-1:0] q [NUM_CH][$];
    logic [1:0] m_ptr = 2'd0;

    function automatic logic [DW-1:0] dat(int k);
        return bus.out_data[k*DW +: DW];
    endfunction

    function automatic logic [CW-1:0] cnt(int k);
        return bus.xfer_cnt[k*CW +: CW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: words are queued when accepted and compared when drained.
    always @(negedge clk) begin
        logic [DW-1:0] exp_d;
        logic [1:0] s;
        if (rst) begin
            for (int k = 0; k < NUM_CH; k++) q[k].delete();
            m_ptr = 2'd0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                n_checks++;
                if (bus.out_valid[k] !== (q[k].size() != 0)) begin
                    n_fail++;
                    $display("FAIL sb_valid ch%0d: got %b want %b", k, bus.out_valid[k], q[k].size() != 0);
                end
                if (bus.out_valid[k] === 1'b1 && bus.out_ready[k] === 1'b1 && q[k].size() != 0) begin
                    exp_d = q[k].pop_front();
                    n_checks++;
                    if (dat(k) !== exp_d) begin
                        n_fail++;
                        $display("FAIL sb_data ch%0d: got %h want %h", k, dat(k), exp_d);
                    end
                end
            end
            if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) begin
`ifdef DEMUX4_RR_EN
                s = m_ptr;
                m_ptr = m_ptr + 2'd1;
`else
                s = bus.in_sel;
`endif
                q[s].push_back(bus.in_data);
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'hFF; bus.out_ready = 4'b1111;
        tick(); tick();
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        n_checks++; if (bus.out_valid !== 4'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0000", bus.out_valid); end
        n_checks++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", bus.out_data); end
        n_checks++; if (bus.xfer_cnt !== 32'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", bus.xfer_cnt); end
        n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b want 0", bus.sel_err); end
        bus.in_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_routing();
        bus.in_valid = 1'b1; bus.in_sel = 2'd3; bus.in_data = 8'hA5; bus.out_ready = 4'b1111;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL route_ready: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== 4'b1000) begin n_fail++; $display("FAIL route_valid: got %b want 1000", bus.out_valid); end
        n_checks++; if (dat(3) !== 8'hA5) begin n_fail++; $display("FAIL route_data: got %h want a5", dat(3)); end
        tick();
        n_checks++; if (cnt(3) !== 8'd1) begin n_fail++; $display("FAIL route_cnt: got %0d want 1", cnt(3)); end
    endtask

    task automatic test_stall();
        bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'h11;
        tick();
        bus.in_data = 8'h22;
        #1;
        n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_blocked: got %b want 0", bus.in_ready); end
        bus.in_sel = 2'd2; bus.in_data = 8'h33;
        #1;
        n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_other: got %b want 1", bus.in_ready); end
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        n_checks++; if (bus.out_valid !== 4'b0110) begin n_fail++; $display("FAIL stall_valid: got %b want 0110", bus.out_valid); end
        n_checks++; if (dat(1) !== 8'h11) begin n_fail++; $display("FAIL stall_hold: got %h want 11", dat(1)); end
        bus.out_ready = 4'b0110;
        tick();
        n_checks++; if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL stall_drain: got %b want 0000", bus.out_valid); end
        n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL stall_err: got %b want 0", bus.sel_err); end
        bus.out_ready = 4'b1111;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'h10 + 8'(i);
            #1;
            n_checks++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready%0d: got %b want 1", i, bus.in_ready); end
            tick();
            n_checks++; if (bus.out_valid[0] !== 1'b1 || dat(0) !== 8'h10 + 8'(i)) begin
                n_fail++; $display("FAIL b2b_out%0d: got %b/%h want 1/%h", i, bus.out_valid[0], dat(0), 8'h10 + 8'(i));
            end
        end
        bus.in_valid = 1'b0;
        tick();
        n_checks++; if (cnt(0) !== 8'd4) begin n_fail++; $display("FAIL b2b_cnt: got %0d want 4", cnt(0)); end
    endtask

    task automatic test_wrap();
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 255; i++) begin
            bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 8'(i);
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        n_checks++; if (cnt(2) !== 8'd0) begin n_fail++; $display("FAIL wrap_cnt2: got %0d want 0", cnt(2)); end
        n_checks++; if (cnt(0) !== 8'd4 || cnt(1) !== 8'd1 || cnt(3) !== 8'd1) begin
            n_fail++; $display("FAIL wrap_others: got %0d/%0d/%0d want 4/1/1", cnt(0), cnt(1), cnt(3));
        end
        bus.in_valid = 1'b1; bus.in_data = 8'hEE;
        tick();
        bus.in_valid = 1'b0;
        tick();
        n_checks++; if (cnt(2) !== 8'd1) begin n_fail++; $display("FAIL wrap_next: got %0d want 1", cnt(2)); end
    endtask

    task automatic test_protocol_err();
        bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'h77;
        tick();
        bus.in_data = 8'h88;
        tick();
        n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL perr_early: got %b want 0", bus.sel_err); end
        bus.in_sel = 2'd1;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.sel_err !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b want 1", bus.sel_err); end
        bus.out_ready = 4'b1111;
        tick(); tick(); tick();
        n_checks++; if (bus.sel_err !== 1'b1) begin n_fail++; $display("FAIL perr_sticky: got %b want 1", bus.sel_err); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_v;
`ifdef DEMUX4_RR_EN
        exp_v = 4'b0011;
`else
        exp_v = 4'b1010;
`endif
        bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 8'h31;
        tick();
        bus.in_sel = 2'd3; bus.in_data = 8'h33;
        #1;
        tick();
        bus.in_valid = 1'b0;
        n_checks++; if (bus.out_valid !== exp_v) begin n_fail++; $display("FAIL rmid_full: got %b want %b", bus.out_valid, exp_v); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL rmid_valid: got %b want 0000", bus.out_valid); end
        n_checks++; if (bus.xfer_cnt !== 32'h0 || bus.out_data !== 32'h0) begin
            n_fail++; $display("FAIL rmid_regs: got cnt %h data %h want 0/0", bus.xfer_cnt, bus.out_data);
        end
        n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b want 0", bus.sel_err); end
    endtask

    task automatic test_withdraw();
        bus.out_ready = 4'b0000;
        bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 8'h40;
        tick();
        bus.in_data = 8'h41;
        tick();
        bus.in_valid = 1'b0;
        tick();
        n_checks++; if (bus.sel_err !== 1'b1) begin n_fail++; $display("FAIL withdraw_err: got %b want 1", bus.sel_err); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.out_ready = 4'b1111;
        n_checks++; if (bus.sel_err !== 1'b0) begin n_fail++; $display("FAIL withdraw_clr: got %b want 0", bus.sel_err); end
    endtask

`ifdef DEMUX4_RR_EN
    task automatic test_rr();
        bus.out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1; bus.in_sel = 2'(3 - (i % 4)); bus.in_data = 8'h50 + 8'(i);
            tick();
            n_checks++; if (bus.out_valid !== 4'(1 << (i % 4)) || dat(i % 4) !== 8'h50 + 8'(i)) begin
                n_fail++; $display("FAIL rr_route%0d: got %b/%h want %b/%h", i, bus.out_valid, dat(i % 4), 4'(1 << (i % 4)), 8'h50 + 8'(i));
            end
        end
        bus.in_valid = 1'b0;
        tick();
    endtask
`endif

    initial begin
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = 8'h00; bus.out_ready = 4'b0000;
        test_reset();
`ifdef DEMUX4_RR_EN
        test_reset_mid();
        test_rr();
`else
        test_routing();
        test_stall();
        test_back_to_back();
        test_wrap();
        test_protocol_err();
        test_reset_mid();
        test_withdraw();
`endif
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/demux4_stream.md
Name: demux4_stream

Overview:
- 1-to-4 stream demultiplexer with valid/ready handshakes; the inverse of the team's 4:1 mux.
- Routes each input word to the output channel chosen by in_sel.
- Each channel has a one-entry holding register, so a stalled consumer blocks only its own channel.
- Sits between a single producer and four independent consumers.

Parameters:
- DATA_W, 8, width of the data word on input and each output.
- CNT_W, 8, width of each per-channel transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  producer has a word.
- in_ready  output  1  block accepts the word this cycle.
- in_sel  input  2  target channel: 00→ch0, 01→ch1, 10→ch2, 11→ch3.
- in_data  input  DATA_W  input word.
- out_valid  output  4  bit k: channel k holds a word.
- out_ready  input  4  bit k: consumer k takes the word.
- out_data  output  4*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- xfer_cnt  output  4*CNT_W  channel k transfer count, same packing as out_data.
- sel_err  output  1  sticky protocol-violation flag.

Behaviour:
- Interface: one clock clk; reset rst is synchronous and active-high.
- Reset (rst=1 at a clock edge): out_valid=0, out_data=0, xfer_cnt=0, sel_err=0.
  - Reset takes effect mid-transfer; held words are discarded.
  - in_ready=0 while rst=1.
- Acceptance:
  - in_ready = !rst & (!out_valid[s] | out_ready[s]), where s = target channel.
  - in_ready is combinational from in_sel and out_ready.
  - Transfer when in_valid & in_ready.
- Latency: word accepted at edge N appears with out_valid[s]=1 from edge N (visible cycle N+1); 1-cycle latency.
- Per-channel slot: two states, EMPTY and FULL.
  - EMPTY→FULL on accept to this channel.
  - FULL→EMPTY on out_ready[k] with no accept to this channel.
  - FULL→FULL with new data on simultaneous drain and accept to the same channel; no bubble, out_valid[k] stays 1.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data[k] is held constant.
- Channel independence: out_ready[k] affects only channel k. A full stalled channel never blocks traffic to other channels.
- xfer_cnt[k]:
  - Increments by 1 on each output handshake (out_valid[k] & out_ready[k]).
  - Wraps from 2^CNT_W-1 to 0.
- sel_err:
  - Set when in_valid=1 and in_ready=0 in cycle N, and in cycle N+1 in_valid=1 with in_sel or in_data changed.
  - Also set when in_valid drops in N+1 without a transfer (valid withdrawn).
  - Cleared only by rst.
  - Requires registering prev in_valid, in_sel and in_data; stall flag = in_valid & !in_ready.
- Routing: a word is never duplicated or dropped; exactly one channel is loaded per accepted transfer.

Optional Feature:
- Macro: DEMUX4_RR_EN.
- Defined:
  - in_sel is ignored.
  - The target comes from an internal 2-bit round-robin pointer; reset value 0.
  - The pointer advances by 1 on each accepted input transfer, wrapping 3→0.
  - in_ready uses the pointer channel; sel_err ignores in_sel changes.
- Not defined: target = in_sel as above, and no pointer register exists.

Decomposition:
- Package demux4_pkg:
  - NUM_CH=4 and SEL_W=2.
  - typedef sel_t (logic [SEL_W-1:0]).
  - Reset constants for counter and data.
- Sub-module demux4_slot: one-entry holding register with load/drain handshake, valid flag and transfer counter.
  - Instantiated 4 times by a generate loop.
  - The top level holds only the select/pointer decode, in_ready mux and sel_err logic.

Test Plan:
- Basic routing: rst 2 cycles, then in_sel=11, in_data=8'hA5, in_valid=1, out_ready=4'b1111 → in_ready=1; next cycle out_valid=4'b1000, out_data[ch3]=A5; xfer_cnt[3]=1 one cycle after that.
- Stall isolation: out_ready=0000; send 11→ch1; then send 22→ch1 → in_ready=0; send 33→ch2 → accepted. out_valid=0110, ch1 data holds 11 until out_ready[1]=1.
- Back-to-back: out_ready=1111, stream 10,11,12,13 to ch0 on consecutive cycles → in_ready stays 1; out_valid[0] stays high 4 cycles with data 10..13 in order; xfer_cnt[0]=4.
- Counter wrap: 256 handshakes on ch2 → xfer_cnt[2] returns to 0; other counters unchanged.
- Protocol error: ch0 full and stalled, in_valid=1, in_sel=00; next cycle change in_sel to 01 → sel_err=1 and remains 1 until rst.
- Reset mid-operation: ch1 and ch3 full, assert rst one cycle → out_valid=0000, xfer_cnt=0, sel_err=0. With DEMUX4_RR_EN, the next 5 accepts land on ch0, ch1, ch2, ch3, ch0.
